// File: rtl/wash_sequencer_if.sv
// Signal bundle between the wash programme sequencer and its environment
// (operator controls, door sensor, shared timer and actuators).
interface wash_sequencer_if;
  logic        start;
  logic        cancel;
  logic        door_closed;
  logic        timer_done;
  logic        timer_start;
  logic [31:0] timer_duration;
  logic        valve_in;
  logic        valve_out;
  logic        motor_wash;
  logic        motor_spin;
  logic        door_lock;
  logic        busy;
  logic        cycle_done;
  logic [2:0]  state;

  // Sequencer side: consumes requests and the timer pulse, drives everything else.
  modport slave (
    input  start, cancel, door_closed, timer_done,
    output timer_start, timer_duration, valve_in, valve_out,
           motor_wash, motor_spin, door_lock, busy, cycle_done, state
  );

  // Environment side: operator/sensor/timer drivers and output observers.
  modport master (
    output start, cancel, door_closed, timer_done,
    input  timer_start, timer_duration, valve_in, valve_out,
           motor_wash, motor_spin, door_lock, busy, cycle_done, state
  );
endinterface

// File: rtl/wash_sequencer.sv
// Wash programme sequencer: walks FILL, WASH, DRAIN, RINSE/DRAIN loop, SPIN,
// loads one timer run per phase, drives actuators and the door lock, and
// falls back to a timed drain (ABORT) on cancel or door-open.
module wash_sequencer #(
  parameter logic [31:0] FILL_TIME  = 32'd100,
  parameter logic [31:0] WASH_TIME  = 32'd400,
  parameter logic [31:0] DRAIN_TIME = 32'd80,
  parameter logic [31:0] RINSE_TIME = 32'd200,
  parameter logic [31:0] SPIN_TIME  = 32'd300,
  parameter logic [3:0]  RINSES     = 4'd2
) (
  input  logic             clk,
  input  logic             reset,
  wash_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_WASH     = 3'd2,
    S_DRAIN    = 3'd3,
    S_RINSE    = 3'd4,
    S_SPIN     = 3'd5,
    S_COMPLETE = 3'd6,
    S_ABORT    = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  rinse_cnt_q, rinse_cnt_d;
  logic        armed_q, armed_d;
  logic        timer_start_q, timer_start_d;
  logic [31:0] timer_duration_q, timer_duration_d;
  logic        valve_in_q, valve_in_d;
  logic        valve_out_q, valve_out_d;
  logic        motor_wash_q, motor_wash_d;
  logic        motor_spin_q, motor_spin_d;
  logic        door_lock_q, door_lock_d;
  logic        busy_q, busy_d;
  logic        cycle_done_q, cycle_done_d;

  logic abort_req_s;
  logic phase_end_s;
  logic entry_s;

  // States that own a timer run.
  function automatic logic is_timed(input state_e s);
    case (s)
      S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_ABORT: is_timed = 1'b1;
      default:                                           is_timed = 1'b0;
    endcase
  endfunction

  // Timer load value for each state; untimed states report zero.
  function automatic logic [31:0] phase_duration(input state_e s);
    case (s)
      S_FILL:  phase_duration = FILL_TIME;
      S_WASH:  phase_duration = WASH_TIME;
      S_DRAIN: phase_duration = DRAIN_TIME;
      S_ABORT: phase_duration = DRAIN_TIME;
      S_RINSE: phase_duration = RINSE_TIME;
      S_SPIN:  phase_duration = SPIN_TIME;
      default: phase_duration = 32'd0;
    endcase
  endfunction

  // Next-state logic: abort outranks a timer expiry; a done only counts once armed.
  always_comb begin
    state_d     = state_q;
    rinse_cnt_d = rinse_cnt_q;
    abort_req_s = bus.cancel | ~bus.door_closed;
    phase_end_s = bus.timer_done & armed_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.door_closed) begin
          state_d     = S_FILL;
          rinse_cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (abort_req_s)      state_d = S_ABORT;
        else if (phase_end_s) state_d = S_WASH;
        else                  state_d = S_FILL;
      end
      S_WASH: begin
        if (abort_req_s)      state_d = S_ABORT;
        else if (phase_end_s) state_d = S_DRAIN;
        else                  state_d = S_WASH;
      end
      S_DRAIN: begin
        if (abort_req_s) begin
          state_d = S_ABORT;
        end else if (phase_end_s) begin
          if (rinse_cnt_q < RINSES) state_d = S_RINSE;
          else                      state_d = S_SPIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_RINSE: begin
        if (abort_req_s) begin
          state_d = S_ABORT;
        end else if (phase_end_s) begin
          state_d     = S_DRAIN;
          rinse_cnt_d = rinse_cnt_q + 4'd1;
        end else begin
          state_d = S_RINSE;
        end
      end
      S_SPIN: begin
        if (abort_req_s)      state_d = S_ABORT;
        else if (phase_end_s) state_d = S_COMPLETE;
        else                  state_d = S_SPIN;
      end
      S_COMPLETE: state_d = S_IDLE;
      S_ABORT: begin
        if (phase_end_s) state_d = S_IDLE;
        else             state_d = S_ABORT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with state.
  always_comb begin
    entry_s          = (state_d != state_q);
    timer_start_d    = entry_s & is_timed(state_d);
    timer_duration_d = phase_duration(state_d);
    if (entry_s)            armed_d = 1'b0;
    else if (timer_start_q) armed_d = 1'b1;
    else                    armed_d = armed_q;
    valve_in_d   = 1'b0;
    valve_out_d  = 1'b0;
    motor_wash_d = 1'b0;
    motor_spin_d = 1'b0;
    case (state_d)
      S_FILL:  valve_in_d = 1'b1;
      S_WASH:  motor_wash_d = 1'b1;
      S_DRAIN: valve_out_d = 1'b1;
      S_ABORT: valve_out_d = 1'b1;
      S_RINSE: begin
        valve_in_d   = 1'b1;
        motor_wash_d = 1'b1;
      end
      S_SPIN: begin
        valve_out_d  = 1'b1;
        motor_spin_d = 1'b1;
      end
      default: valve_in_d = 1'b0;
    endcase
    door_lock_d  = (state_d != S_IDLE) && (state_d != S_COMPLETE);
    busy_d       = door_lock_d;
    cycle_done_d = (state_d == S_COMPLETE);
  end

  // State, counters and registered outputs; reset drops everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      rinse_cnt_q      <= 4'd0;
      armed_q          <= 1'b0;
      timer_start_q    <= 1'b0;
      timer_duration_q <= 32'd0;
      valve_in_q       <= 1'b0;
      valve_out_q      <= 1'b0;
      motor_wash_q     <= 1'b0;
      motor_spin_q     <= 1'b0;
      door_lock_q      <= 1'b0;
      busy_q           <= 1'b0;
      cycle_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      rinse_cnt_q      <= rinse_cnt_d;
      armed_q          <= armed_d;
      timer_start_q    <= timer_start_d;
      timer_duration_q <= timer_duration_d;
      valve_in_q       <= valve_in_d;
      valve_out_q      <= valve_out_d;
      motor_wash_q     <= motor_wash_d;
      motor_spin_q     <= motor_spin_d;
      door_lock_q      <= door_lock_d;
      busy_q           <= busy_d;
      cycle_done_q     <= cycle_done_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.timer_start    = timer_start_q;
  assign bus.timer_duration = timer_duration_q;
  assign bus.valve_in       = valve_in_q;
  assign bus.valve_out      = valve_out_q;
  assign bus.motor_wash     = motor_wash_q;
  assign bus.motor_spin     = motor_spin_q;
  assign bus.door_lock      = door_lock_q;
  assign bus.busy           = busy_q;
  assign bus.cycle_done     = cycle_done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: two instances (one rinse pass / no rinse) each
// paired with a model of the shared down-counter timer. Expected phases are
// queued when a programme is started and compared as each phase ends.
module tb_wash_sequencer;

  logic clk;
  logic reset;
  wash_sequencer_if ifa ();
  wash_sequencer_if ifb ();

  typedef struct {
    logic [2:0] st;
    int         len;
  } phase_t;

  phase_t sb[$];
  int     checks;
  int     failures;
  int     cd_cnt;
  int     total;
  logic   fake_a;

  wash_sequencer #(
    .FILL_TIME(32'd3), .WASH_TIME(32'd5), .DRAIN_TIME(32'd2),
    .RINSE_TIME(32'd4), .SPIN_TIME(32'd6), .RINSES(4'd1)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  wash_sequencer #(
    .FILL_TIME(32'd3), .WASH_TIME(32'd5), .DRAIN_TIME(32'd2),
    .RINSE_TIME(32'd4), .SPIN_TIME(32'd6), .RINSES(4'd0)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer models: a load reloads even a running count; done pulses one cycle
  // after the count has sat at zero.
  logic [31:0] t_cnt_a, t_cnt_b;
  logic        t_run_a, t_run_b, t_done_a, t_done_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_cnt_a <= 32'd0; t_run_a <= 1'b0; t_done_a <= 1'b0;
    end else begin
      t_done_a <= 1'b0;
      if (ifa.timer_start) begin
        t_cnt_a <= ifa.timer_duration; t_run_a <= 1'b1;
      end else if (t_run_a) begin
        if (t_cnt_a == 32'd0) begin t_done_a <= 1'b1; t_run_a <= 1'b0; end
        else t_cnt_a <= t_cnt_a - 32'd1;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_cnt_b <= 32'd0; t_run_b <= 1'b0; t_done_b <= 1'b0;
    end else begin
      t_done_b <= 1'b0;
      if (ifb.timer_start) begin
        t_cnt_b <= ifb.timer_duration; t_run_b <= 1'b1;
      end else if (t_run_b) begin
        if (t_cnt_b == 32'd0) begin t_done_b <= 1'b1; t_run_b <= 1'b0; end
        else t_cnt_b <= t_cnt_b - 32'd1;
      end
    end
  end

  assign ifa.timer_done = t_done_a | fake_a;
  assign ifb.timer_done = t_done_b;

  function automatic logic [2:0] cur_state(input bit sel);
    return sel ? ifb.state : ifa.state;
  endfunction

  function automatic logic cur_cd(input bit sel);
    return sel ? ifb.cycle_done : ifa.cycle_done;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_phase(input logic [2:0] st, input int len);
    phase_t p;
    p.st  = st;
    p.len = len;
    sb.push_back(p);
  endtask

  // Measures the phase starting at the current cycle and compares it with the
  // oldest queued expectation. pulse: 1 = fake done in the first cycle,
  // 2 = start request in the first cycle (instance A only).
  task automatic check_phase(input bit sel, input int pulse);
    phase_t     e;
    logic [2:0] st;
    int         len;
    if (sb.size() == 0) begin
      e.st = 3'd0; e.len = 0;
    end else begin
      e = sb.pop_front();
    end
    st  = cur_state(sel);
    len = 0;
    if (pulse == 1) fake_a = 1'b1;
    if (pulse == 2) ifa.start = 1'b1;
    do begin
      if (cur_cd(sel)) cd_cnt++;
      len++;
      @(negedge clk);
      fake_a = 1'b0;
      if (pulse == 2) ifa.start = 1'b0;
    end while (cur_state(sel) == st && len < 100);
    chk("phase_state", {29'd0, st}, {29'd0, e.st});
    chk("phase_len", len, e.len);
    total += len;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cd_cnt = 0; total = 0; fake_a = 1'b0;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.cancel = 1'b0; ifa.door_closed = 1'b1;
    ifb.start = 1'b0; ifb.cancel = 1'b0; ifb.door_closed = 1'b1;

    // Reset values.
    @(negedge clk);
    chk("rst_state", {29'd0, ifa.state}, 32'd0);
    chk("rst_duration", ifa.timer_duration, 32'd0);
    chk("rst_outputs", {24'd0, ifa.timer_start, ifa.valve_in, ifa.valve_out, ifa.motor_wash,
        ifa.motor_spin, ifa.door_lock, ifa.busy, ifa.cycle_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", {29'd0, ifa.state}, 32'd0);

    // Full programme with one rinse pass.
    push_phase(3'd1, 6); push_phase(3'd2, 8); push_phase(3'd3, 5); push_phase(3'd4, 7);
    push_phase(3'd3, 5); push_phase(3'd5, 9); push_phase(3'd6, 1);
    pulse_start(1'b0);
    chk("fill_entry_ts", {31'd0, ifa.timer_start}, 32'd1);
    chk("fill_entry_dur", ifa.timer_duration, 32'd3);
    chk("fill_acts", {28'd0, ifa.valve_in, ifa.valve_out, ifa.door_lock, ifa.busy}, 32'b1011);
    total = 0; cd_cnt = 0;
    for (int i = 0; i < 7; i++) check_phase(1'b0, 0);
    chk("full_end_state", {29'd0, ifa.state}, 32'd0);
    chk("full_total", total, 32'd41);
    chk("full_cycle_done", cd_cnt, 32'd1);

    // No rinse passes.
    push_phase(3'd1, 6); push_phase(3'd2, 8); push_phase(3'd3, 5);
    push_phase(3'd5, 9); push_phase(3'd6, 1);
    pulse_start(1'b1);
    total = 0; cd_cnt = 0;
    for (int i = 0; i < 5; i++) check_phase(1'b1, 0);
    chk("norinse_end", {29'd0, ifb.state}, 32'd0);
    chk("norinse_total", total, 32'd29);
    chk("norinse_cd", cd_cnt, 32'd1);
    chk("norinse_cnt", {28'd0, dut_b.rinse_cnt_q}, 32'd0);

    // Cancel in the 4th WASH cycle.
    push_phase(3'd1, 6);
    pulse_start(1'b0);
    cd_cnt = 0;
    check_phase(1'b0, 0);
    repeat (3) @(negedge clk);
    ifa.cancel = 1'b1;
    @(negedge clk);
    ifa.cancel = 1'b0;
    chk("cancel_state", {29'd0, ifa.state}, 32'd7);
    chk("cancel_ts", {31'd0, ifa.timer_start}, 32'd1);
    chk("cancel_dur", ifa.timer_duration, 32'd2);
    chk("cancel_acts", {29'd0, ifa.valve_out, ifa.motor_wash, ifa.valve_in}, 32'b100);
    push_phase(3'd7, 5);
    check_phase(1'b0, 0);
    chk("cancel_idle", {29'd0, ifa.state}, 32'd0);
    chk("cancel_no_cd", cd_cnt, 32'd0);

    // Door opens during SPIN; a start during ABORT is ignored.
    push_phase(3'd1, 6); push_phase(3'd2, 8); push_phase(3'd3, 5);
    push_phase(3'd4, 7); push_phase(3'd3, 5);
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) check_phase(1'b0, 0);
    chk("spin_motor", {31'd0, ifa.motor_spin}, 32'd1);
    @(negedge clk);
    ifa.door_closed = 1'b0;
    @(negedge clk);
    chk("door_abort", {29'd0, ifa.state}, 32'd7);
    chk("door_motor_off", {30'd0, ifa.motor_spin, ifa.valve_out}, 32'b01);
    ifa.door_closed = 1'b1;
    cd_cnt = 0;
    push_phase(3'd7, 5);
    check_phase(1'b0, 2);
    chk("door_idle", {29'd0, ifa.state}, 32'd0);
    @(negedge clk);
    chk("door_stay_idle", {29'd0, ifa.state}, 32'd0);
    chk("door_no_cd", cd_cnt, 32'd0);

    // Fake done in the DRAIN start cycle, then async reset mid-RINSE.
    push_phase(3'd1, 6); push_phase(3'd2, 8);
    pulse_start(1'b0);
    check_phase(1'b0, 0);
    check_phase(1'b0, 0);
    chk("drain_entry_ts", {31'd0, ifa.timer_start}, 32'd1);
    push_phase(3'd3, 5);
    check_phase(1'b0, 1);
    chk("rinse_state", {29'd0, ifa.state}, 32'd4);
    @(negedge clk);
    chk("rinse_acts", {30'd0, ifa.valve_in, ifa.motor_wash}, 32'b11);
    #2 reset = 1'b1;
    #1;
    chk("areset_state", {29'd0, ifa.state}, 32'd0);
    chk("areset_outputs", {24'd0, ifa.timer_start, ifa.valve_in, ifa.valve_out, ifa.motor_wash,
        ifa.motor_spin, ifa.door_lock, ifa.busy, ifa.cycle_done}, 32'd0);
    chk("areset_dur", ifa.timer_duration, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ifa.door_closed = 1'b0;
    ifa.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("open_start_state", {29'd0, ifa.state}, 32'd0);
    chk("open_start_lock", {30'd0, ifa.door_lock, ifa.busy}, 32'd0);
    ifa.start = 1'b0;
    ifa.door_closed = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
